// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg
// Shared definitions for the load/store data memory:
//   - RISC-V load/store funct3 encodings
//   - control FSM state encoding
//   - access_size(): access width in bytes for a given funct3
package lsu_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // The low two funct3 bits encode log2 of the access size.
  function automatic logic [3:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram
// Single-port synchronous RAM, DEPTH x WORDSIZE, per-byte write enable,
// registered read.
// Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   per-byte write enable (all zero = read)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  read data, updated only by a read access
module sp_ram #(
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 1024
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [WORDSIZE/8-1:0]      we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [WORDSIZE-1:0]        wdata,
  output logic [WORDSIZE-1:0]        rdata
);

  localparam int NB = WORDSIZE / 8;

  logic [WORDSIZE-1:0] mem_r [DEPTH];
  logic [WORDSIZE-1:0] rdata_r;

  // Byte-lane writes; the read register only changes on a pure read so a
  // captured load result survives until the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      if (we == {NB{1'b0}}) begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem
// Byte-addressed data memory for the load/store path with a valid/ready
// request/response handshake, RV64 load/store sizes, sign/zero extension,
// alignment/range checking, configurable latency and zero-fill after reset.
// Ports:
//   clk, rst (sync, active low)
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  request side
//   resp_valid/resp_ready/resp_rdata/resp_err                 response side
//   clearing                                                  zero-fill active
module lsu_data_mem
  import lsu_mem_pkg::*;
#(
  parameter int ADDRSIZE = 64,
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDRSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_err,
  output logic                clearing
);

  localparam int NB        = WORDSIZE / 8;
  localparam int OFF       = $clog2(NB);
  localparam int SHW       = $clog2(WORDSIZE);
  localparam int AW        = $clog2(DEPTH);
  localparam int WW        = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int WAIT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

  lsu_state_e          state_r, state_nx_s;
  logic [AW-1:0]       clr_cnt_r;
  logic [WW-1:0]       wait_cnt_r;
  logic                err_r, we_r;
  logic [2:0]          f3_r;
  logic [OFF-1:0]      off_r;

  logic [3:0]          size_s;
  logic [OFF-1:0]      off_s, align_s;
  logic [ADDRSIZE-1:0] idx_s;
  logic                req_err_s, accept_s;
  logic [NB-1:0]       bmask_s;
  logic [SHW-1:0]      shift_s;

  logic                ram_en_s;
  logic [NB-1:0]       ram_we_s;
  logic [AW-1:0]       ram_addr_s;
  logic [WORDSIZE-1:0] ram_wdata_s, ram_rdata_s;
  logic [WORDSIZE-1:0] lane_s, ext_s;

  assign accept_s = (state_r == ST_IDLE) && req_valid;

  // Request decode: address split, error checks, byte-lane mask.
  always_comb begin
    size_s    = access_size(req_funct3);
    off_s     = req_addr[OFF-1:0];
    idx_s     = req_addr >> OFF;
    align_s   = OFF'(size_s - 4'd1);
    shift_s   = {off_s, 3'b000};
    req_err_s = ((off_s & align_s) != {OFF{1'b0}})
             || (idx_s >= ADDRSIZE'(DEPTH))
             || (req_funct3 == 3'b111)
             || ((WORDSIZE == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)))
             || (req_we && req_funct3[2]);
    for (int i = 0; i < NB; i++) begin
      bmask_s[i] = (i >= int'(off_s)) && (i < int'(off_s) + int'(size_s));
    end
  end

  // State register; reset parks the FSM in zero-fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Fill counter, latency counter and capture of the accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_cnt_r  <= {AW{1'b0}};
      wait_cnt_r <= {WW{1'b0}};
      err_r      <= 1'b0;
      we_r       <= 1'b0;
      f3_r       <= 3'b000;
      off_r      <= {OFF{1'b0}};
    end else begin
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + AW'(1);
      end else begin
        clr_cnt_r <= {AW{1'b0}};
      end
      if (accept_s) begin
        wait_cnt_r <= WW'(WAIT_LOAD);
        err_r      <= req_err_s;
        we_r       <= req_we;
        f3_r       <= req_funct3;
        off_r      <= off_s;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r - WW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == AW'(DEPTH - 1)) state_nx_s = ST_IDLE;
        else                             state_nx_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) state_nx_s = ST_WAIT;
          else             state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == {WW{1'b0}}) state_nx_s = ST_RESP;
        else                          state_nx_s = ST_WAIT;
      end
      ST_RESP: begin
        if (resp_ready) state_nx_s = ST_IDLE;
        else            state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_CLEAR;
    endcase
  end

  // FSM outputs and RAM port control. Erroring requests never touch the RAM.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    clearing    = 1'b0;
    ram_en_s    = 1'b0;
    ram_we_s    = {NB{1'b0}};
    ram_addr_s  = idx_s[AW-1:0];
    ram_wdata_s = req_wdata << shift_s;
    case (state_r)
      ST_CLEAR: begin
        clearing    = 1'b1;
        ram_en_s    = 1'b1;
        ram_we_s    = {NB{1'b1}};
        ram_addr_s  = clr_cnt_r;
        ram_wdata_s = {WORDSIZE{1'b0}};
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_err_s) begin
          ram_en_s = 1'b1;
          ram_we_s = req_we ? bmask_s : {NB{1'b0}};
        end else begin
          ram_en_s = 1'b0;
        end
      end
      ST_WAIT: resp_valid = 1'b0;
      ST_RESP: resp_valid = 1'b1;
      default: clearing   = 1'b0;
    endcase
  end

  // Load extraction and extension from the captured read word.
  always_comb begin
    lane_s = ram_rdata_s >> {off_r, 3'b000};
    case (f3_r)
      F3_B:    ext_s = WORDSIZE'($signed(lane_s[7:0]));
      F3_H:    ext_s = WORDSIZE'($signed(lane_s[15:0]));
      F3_W:    ext_s = WORDSIZE'($signed(lane_s[31:0]));
      F3_BU:   ext_s = WORDSIZE'(lane_s[7:0]);
      F3_HU:   ext_s = WORDSIZE'(lane_s[15:0]);
      F3_WU:   ext_s = WORDSIZE'(lane_s[31:0]);
      default: ext_s = lane_s;
    endcase
    if ((state_r == ST_RESP) && !err_r && !we_r) resp_rdata = ext_s;
    else                                         resp_rdata = {WORDSIZE{1'b0}};
    resp_err = (state_r == ST_RESP) && err_r;
  end

  sp_ram #(
    .WORDSIZE (WORDSIZE),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem
// Self-checking bench for lsu_data_mem (DEPTH 16, LATENCY 3). Expected
// values come from a byte-array memory model and the load/store rules.
module tb_lsu_data_mem;

  localparam int ADDRSIZE = 64;
  localparam int WORDSIZE = 64;
  localparam int DEPTH    = 16;
  localparam int LATENCY  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid, req_ready, req_we;
  logic [2:0]          req_funct3;
  logic [ADDRSIZE-1:0] req_addr;
  logic [WORDSIZE-1:0] req_wdata;
  logic                resp_valid, resp_ready, resp_err, clearing;
  logic [WORDSIZE-1:0] resp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] mem_m [DEPTH*8];

  lsu_data_mem #(
    .ADDRSIZE (ADDRSIZE),
    .WORDSIZE (WORDSIZE),
    .DEPTH    (DEPTH),
    .LATENCY  (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .clearing   (clearing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [63:0] addr);
    logic [63:0] size;
    size = 64'd1 << f3[1:0];
    return (f3 == 3'b111) || (we && f3[2]) || ((addr % size) != 64'd0) || ((addr / 64'd8) >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
    int size;
    logic [63:0] v;
    size = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < size; i++) v = v | (64'(mem_m[int'(addr[6:0]) + i]) << (8 * i));
    if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata);
    int size;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) mem_m[int'(addr[6:0]) + i] = wdata[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH*8; i++) mem_m[i] = 8'h00;
  endtask

  // One full transaction with resp_ready held high. Called and returns at a negedge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat, output int acc);
    int guard;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin n_cmp++; n_fail++; $display("FAIL req_ready_wait: got 0 expected 1"); end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    if (lat >= 50) begin n_cmp++; n_fail++; $display("FAIL resp_valid_wait: got 0 expected 1"); end
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic [63:0] rd; logic er; int lat, acc;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req_ready, resp_valid, resp_err, clearing} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags: got %b expected 0001", {req_ready, resp_valid, resp_err, clearing}); end
    n_cmp++; if (resp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    rst = 1'b1;
    n = 0;
    while (clearing === 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n !== DEPTH) begin n_fail++; $display("FAIL fill_cycles: got %0d expected %0d", n, DEPTH); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_fill: got %b expected 1", req_ready); end
    do_req(1'b0, 3'b011, 64'h78, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'd0) begin n_fail++; $display("FAIL ld_78_rdata: got %h expected 0", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_78_err: got %b expected 0", er); end
  endtask

  task automatic test_byte();
    logic [63:0] rd; logic er; int lat, acc;
    do_req(1'b1, 3'b000, 64'h13, 64'hFF, rd, er, lat, acc); model_store(3'b000, 64'h13, 64'hFF);
    n_cmp++; if ({er, rd} !== 65'd0) begin n_fail++; $display("FAIL sb_13: got err %b data %h expected err 0 data 0", er, rd); end
    do_req(1'b0, 3'b000, 64'h13, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL lb_13: got %h expected ffffffffffffffff", rd); end
    do_req(1'b0, 3'b100, 64'h13, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'h0000_0000_0000_00FF) begin n_fail++; $display("FAIL lbu_13: got %h expected ff", rd); end
    do_req(1'b0, 3'b011, 64'h10, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'h0000_0000_FF00_0000) begin n_fail++; $display("FAIL ld_10: got %h expected ff000000", rd); end
  endtask

  task automatic test_merge();
    logic [63:0] rd; logic er; int lat, acc;
    do_req(1'b1, 3'b011, 64'h20, 64'h1122334455667788, rd, er, lat, acc); model_store(3'b011, 64'h20, 64'h1122334455667788);
    do_req(1'b1, 3'b001, 64'h22, 64'h000000000000ABCD, rd, er, lat, acc); model_store(3'b001, 64'h22, 64'h000000000000ABCD);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sh_22_err: got %b expected 0", er); end
    do_req(1'b0, 3'b011, 64'h20, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'h11223344ABCD7788) begin n_fail++; $display("FAIL ld_20_merge: got %h expected 11223344abcd7788", rd); end
    do_req(1'b0, 3'b010, 64'h24, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'h0000_0000_1122_3344) begin n_fail++; $display("FAIL lw_24: got %h expected 11223344", rd); end
    do_req(1'b0, 3'b001, 64'h22, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_ABCD) begin n_fail++; $display("FAIL lh_22: got %h expected ffffffffffffabcd", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat, acc;
    do_req(1'b1, 3'b011, 64'h0, 64'h0123456789ABCDEF, rd, er, lat, acc); model_store(3'b011, 64'h0, 64'h0123456789ABCDEF);
    do_req(1'b1, 3'b010, 64'h2, 64'hDEADBEEF, rd, er, lat, acc);
    n_cmp++; if ({er, rd} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL sw_misaligned: got err %b data %h expected err 1 data 0", er, rd); end
    do_req(1'b0, 3'b011, 64'h0, 64'd0, rd, er, lat, acc);
    n_cmp++; if ({er, rd} !== {1'b0, 64'h0123456789ABCDEF}) begin n_fail++; $display("FAIL ld_0_unchanged: got err %b data %h expected err 0 data 0123456789abcdef", er, rd); end
    do_req(1'b0, 3'b011, 64'(DEPTH*8), 64'd0, rd, er, lat, acc);
    n_cmp++; if ({er, rd} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL ld_out_of_range: got err %b data %h expected err 1 data 0", er, rd); end
    do_req(1'b0, 3'b111, 64'h8, 64'd0, rd, er, lat, acc);
    n_cmp++; if ({er, rd} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL funct3_111: got err %b data %h expected err 1 data 0", er, rd); end
    do_req(1'b1, 3'b100, 64'h8, 64'hFF, rd, er, lat, acc);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL store_unsigned_size: got %b expected 1", er); end
    do_req(1'b0, 3'b011, 64'h8, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'd0) begin n_fail++; $display("FAIL ld_8_untouched: got %h expected 0", rd); end
  endtask

  task automatic test_backpressure();
    int lat, guard;
    logic [63:0] held;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h20; req_wdata = 64'd0;
    resp_ready = 1'b0;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 64'h0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== LATENCY) begin n_fail++; $display("FAIL latency: got %0d expected %0d", lat, LATENCY); end
    held = resp_rdata;
    n_cmp++; if (held !== model_load(3'b011, 64'h20)) begin n_fail++; $display("FAIL bp_rdata: got %h expected %h", held, model_load(3'b011, 64'h20)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, held}) begin n_fail++; $display("FAIL bp_hold_%0d: got valid %b ready %b data %h expected valid 1 ready 0 data %h", i, resp_valid, req_ready, resp_rdata, held); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got valid %b ready %b expected valid 0 ready 1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int lat, acc, prev;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 3'b010, 64'h20 + 64'(4 * (i % 2)), 64'd0, rd, er, lat, acc);
      n_cmp++; if (rd !== model_load(3'b010, 64'h20 + 64'(4 * (i % 2)))) begin n_fail++; $display("FAIL b2b_data_%0d: got %h expected %h", i, rd, model_load(3'b010, 64'h20 + 64'(4 * (i % 2)))); end
      n_cmp++; if (lat !== LATENCY) begin n_fail++; $display("FAIL b2b_latency_%0d: got %0d expected %0d", i, lat, LATENCY); end
      if (prev >= 0) begin
        n_cmp++; if (acc - prev !== LATENCY + 1) begin n_fail++; $display("FAIL b2b_period_%0d: got %0d expected %0d", i, acc - prev, LATENCY + 1); end
      end
      prev = acc;
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, addr, wdata, size, exp_d; logic er, we, exp_e; logic [2:0] f3;
    int lat, acc, sel;
    for (int n = 0; n < 150; n++) begin
      f3    = 3'($urandom_range(0, 7));
      we    = 1'($urandom);
      wdata = {$urandom, $urandom};
      size  = 64'd1 << f3[1:0];
      sel   = $urandom_range(0, 9);
      if (sel < 7)      addr = 64'($urandom_range(0, DEPTH*8 + 7)) & ~(size - 64'd1);
      else if (sel < 9) addr = 64'($urandom_range(0, DEPTH*8 - 1));
      else              addr = {$urandom, $urandom};
      exp_e = model_err(we, f3, addr);
      exp_d = (!exp_e && !we) ? model_load(f3, addr) : 64'd0;
      do_req(we, f3, addr, wdata, rd, er, lat, acc);
      if (!exp_e && we) model_store(f3, addr, wdata);
      n_cmp++; if ({er, rd} !== {exp_e, exp_d}) begin n_fail++; $display("FAIL rand_%0d we %b f3 %b addr %h: got err %b data %h expected err %b data %h", n, we, f3, addr, er, rd, exp_e, exp_d); end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] rd; logic er; int lat, acc, guard, n, bad;
    do_req(1'b1, 3'b011, 64'h30, 64'hDEADBEEFCAFEF00D, rd, er, lat, acc); model_store(3'b011, 64'h30, 64'hDEADBEEFCAFEF00D);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h30;
    resp_ready = 1'b0;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reach_resp: got %b expected 1", resp_valid); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req_ready, resp_valid, resp_err, clearing} !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 0001", {req_ready, resp_valid, resp_err, clearing}); end
    @(negedge clk);
    rst = 1'b1; resp_ready = 1'b1;
    model_clear();
    n = 0; bad = 0;
    while (clearing === 1'b1 && n < 100) begin @(negedge clk); n++; if (resp_valid !== 1'b0) bad++; end
    n_cmp++; if (n !== DEPTH) begin n_fail++; $display("FAIL mid_fill_cycles: got %0d expected %0d", n, DEPTH); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mid_stray_resp: got %0d expected 0", bad); end
    do_req(1'b0, 3'b011, 64'h30, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'd0) begin n_fail++; $display("FAIL mid_ld_30: got %h expected 0", rd); end
    do_req(1'b0, 3'b011, 64'h20, 64'd0, rd, er, lat, acc);
    n_cmp++; if (rd !== 64'd0) begin n_fail++; $display("FAIL mid_ld_20: got %h expected 0", rd); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_merge();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
